// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: holds the PLL in reset, waits for lock, checks that lock is stable, then
// releases the system reset. It retries a bounded number of times before latching a fault.
module pll_lock_sequencer #(
  parameter int RESET_CYCLES  = 48,
  parameter int LOCK_TIMEOUT  = 480000,
  parameter int STABLE_CYCLES = 4800,
  parameter int MAX_RETRIES   = 4
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       force_reset,
  input  logic       retry_req,
  output logic       pll_resetb,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] relock_count,
  output logic [2:0] state
);

  localparam int TMAX_A  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX    = (TMAX_A > STABLE_CYCLES) ? TMAX_A : STABLE_CYCLES;
  localparam int TIMER_W = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         retry_q, retry_d;
  logic [7:0]         relock_q, relock_d;
  logic               sync1_q, lock_s_q;
  logic               pll_resetb_q, pll_resetb_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;

  // locked comes from the PLL's own clock domain, so it passes through two flops first
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= locked;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    relock_d = relock_q;
    case (state_q)
      PLL_RST: begin
        if (timer_q == TIMER_W'(RESET_CYCLES - 1)) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = STABLE;
        end else if (timer_q == TIMER_W'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + 4'd1;
          state_d = (retry_d == 4'(MAX_RETRIES)) ? FAULT : PLL_RST;
        end
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (timer_q == TIMER_W'(STABLE_CYCLES - 1)) begin
          state_d = RUN;
          retry_d = 4'd0;
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = PLL_RST;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end
      end
      FAULT: begin
        if (retry_req) begin
          state_d = PLL_RST;
          retry_d = 4'd0;
        end
      end
      default: state_d = PLL_RST;
    endcase

    // A forced restart overrides the state move but keeps any relock already counted above
    if (force_reset) begin
      state_d = PLL_RST;
      retry_d = 4'd0;
    end

    timer_d = ((state_d != state_q) || force_reset) ? '0 : timer_q + 1'b1;

    pll_resetb_d = (state_d != PLL_RST) && (state_d != FAULT);
    sys_rst_n_d  = (state_d == RUN);
    ready_d      = (state_d == RUN);
    fault_d      = (state_d == FAULT);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= PLL_RST;
      timer_q      <= '0;
      retry_q      <= 4'd0;
      relock_q     <= 8'd0;
      pll_resetb_q <= 1'b0;
      sys_rst_n_q  <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      relock_q     <= relock_d;
      pll_resetb_q <= pll_resetb_d;
      sys_rst_n_q  <= sys_rst_n_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  assign pll_resetb   = pll_resetb_q;
  assign sys_rst_n    = sys_rst_n_q;
  assign ready        = ready_q;
  assign fault        = fault_q;
  assign relock_count = relock_q;
  assign state        = state_q;

endmodule
